// File: rtl/frame_buffer_pkg.sv
// Shared types for the frame buffer read path: FSM encoding and stream FIFO depth.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

    localparam int unsigned FB_FIFO_DEPTH = 2;

endpackage

// File: rtl/fb_stream_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so the output stays stable until popped.
module fb_stream_fifo2 #(
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       fill;
    logic             pop_en, push_en;

    assign pop_en  = pop_i && (count_q != 2'd0);
    assign push_en = push_i && ((count_q != 2'd2) || pop_en);
    // occupancy after the pop, used to pick the slot the push lands in
    assign fill    = count_q - {1'b0, pop_en};

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = fill;
        if (pop_en) begin
            mem0_d = mem1_q;
        end
        if (push_en) begin
            count_d = fill + 2'd1;
            if (fill == 2'd0) begin
                mem0_d = push_data_i;
            end else begin
                mem1_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/frame_buffer_raster_reader.sv
// Raster-scans one frame out of the BRAM frame buffer and streams it with SOF/EOL sideband.
module frame_buffer_raster_reader
    import frame_buffer_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    FRAME_WIDTH  = 320,
    parameter int                    FRAME_HEIGHT = 240,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tuser_o,
    output logic                  m_tlast_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
    localparam int EW = DATA_WIDTH + 2;

    fb_state_e             state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q;
    logic                  sof_q, sof_d;
    logic                  eol_q, eol_d;
    logic                  frame_done_q;
    logic                  drain_exit;

    logic [EW-1:0]         head;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    // held-back pixels plus the one still in the BRAM pipeline, net of this cycle's pop
    assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == ST_RUN) && (occ < 3'(FB_FIFO_DEPTH));
    assign pop   = m_tvalid_o && m_tready_i;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        drain_exit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    sof_d  = (x_q == '0) && (y_q == '0);
                    eol_d  = (x_q == X_LAST);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // leave on the edge that accepts the final pixel
                if (!inflight_q && (fifo_count == 2'd1) && pop) begin
                    drain_exit = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                    addr_d     = BASE_ADDR;
                    state_d    = continuous_i ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= BASE_ADDR;
            inflight_q   <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            inflight_q   <= issue;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= drain_exit;
        end
    end

    fb_stream_fifo2 #(
        .WIDTH (EW)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (inflight_q),
        .push_data_i ({eol_q, sof_q, rd_data_i}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    // valid is masked during reset so nothing is handed off in the cycle being flushed
    assign m_tvalid_o   = fifo_valid && !reset_i;
    assign m_tdata_o    = head[DATA_WIDTH-1:0];
    assign m_tuser_o    = head[DATA_WIDTH];
    assign m_tlast_o    = head[DATA_WIDTH+1];
    assign addr_rd_o    = addr_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_buffer_raster_reader.sv
// Directed bench for frame_buffer_raster_reader with a 4x2 frame at base address 16.
module tb_frame_buffer_raster_reader;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic [31:0] addr_rd_o;
    logic [15:0] rd_data_i = '0;
    logic [15:0] m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tready_i = 1'b1;
    logic        m_tuser_o;
    logic        m_tlast_o;
    logic        busy_o;
    logic        frame_done_o;

    int total = 0;
    int bad   = 0;

    logic [17:0] acc_q[$];
    int          acc_cyc[$];
    int          iss_cnt = 0;
    int          done_cnt = 0;
    int          mcyc = 0;
    int          rdy_mode = 0;

    frame_buffer_raster_reader #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (16),
        .FRAME_WIDTH  (4),
        .FRAME_HEIGHT (2),
        .BASE_ADDR    (32'd16)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .addr_rd_o    (addr_rd_o),
        .rd_data_i    (rd_data_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // frame buffer: one-cycle read latency, data = address + 0x100
    always @(posedge clk) rd_data_i <= 16'(addr_rd_o + 32'h100);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ready driver: 0 = always ready, 1 = fixed pseudo-random pattern, 2 = held low
    initial begin
        logic [15:0] pat;
        int pi;
        pat = 16'b1001_1101_0011_0110;
        pi  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready_i = 1'b1;
                1: begin
                    m_tready_i = pat[pi];
                    pi = (pi + 1) % 16;
                end
                default: m_tready_i = 1'b0;
            endcase
        end
    end

    // monitor: collects accepted pixels, checks hold-while-stalled and outstanding reads
    initial begin
        logic        stall_prev;
        logic [15:0] pdata;
        logic        puser, plast;
        logic [31:0] paddr;
        stall_prev = 1'b0;
        pdata = '0;
        puser = 1'b0;
        plast = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!reset_i) begin
                if (stall_prev) begin
                    chk("hold_vld", 32'(m_tvalid_o), 32'd1);
                    chk("hold_data", 32'(m_tdata_o), 32'(pdata));
                    chk("hold_user", 32'(m_tuser_o), 32'(puser));
                    chk("hold_last", 32'(m_tlast_o), 32'(plast));
                end
                if (busy_o && (addr_rd_o == paddr + 32'd1)) iss_cnt++;
                chk("outstanding", 32'((iss_cnt - acc_q.size()) <= 2), 32'd1);
                if (m_tvalid_o && m_tready_i) begin
                    acc_q.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
                    acc_cyc.push_back(mcyc);
                end
                if (frame_done_o) begin
                    done_cnt++;
                    chk("done_busy", 32'(busy_o), 32'(continuous_i));
                end
            end
            stall_prev = m_tvalid_o && !m_tready_i && !reset_i;
            pdata = m_tdata_o;
            puser = m_tuser_o;
            plast = m_tlast_o;
            paddr = addr_rd_o;
        end
    end

    task automatic start_frame();
        acc_q.delete();
        acc_cyc.delete();
        iss_cnt  = 0;
        done_cnt = 0;
        start_i  = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_stream(input int n);
        logic [17:0] e;
        chk("npix", 32'(acc_q.size()), 32'(n));
        for (int k = 0; k < n && k < acc_q.size(); k++) begin
            e = {((k % 8) == 0), ((k % 4) == 3), 16'(16'h110 + (k % 8))};
            chk($sformatf("pix%0d", k), 32'(acc_q[k]), 32'(e));
        end
    endtask

    task automatic check_gap(input int n);
        if (acc_cyc.size() >= n) chk("gap", 32'(acc_cyc[n-1] - acc_cyc[0]), 32'(n - 1));
        else chk("gap_cnt", 32'(acc_cyc.size()), 32'(n));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_addr", addr_rd_o, 32'd16);
        chk("rst_data", 32'(m_tdata_o), 32'd0);
        chk("rst_vld", 32'(m_tvalid_o), 32'd0);
        chk("rst_user", 32'(m_tuser_o), 32'd0);
        chk("rst_last", 32'(m_tlast_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        @(posedge clk);
        #1;

        // single frame, always ready: startup latency then 8 back-to-back pixels
        start_frame();
        @(negedge clk);
        chk("s1_busy", 32'(busy_o), 32'd1);
        chk("s1_addr0", addr_rd_o, 32'd16);
        chk("s1_vld0", 32'(m_tvalid_o), 32'd0);
        @(negedge clk);
        chk("s1_vld1", 32'(m_tvalid_o), 32'd0);
        chk("s1_addr1", addr_rd_o, 32'd17);
        @(negedge clk);
        chk("s1_vld2", 32'(m_tvalid_o), 32'd1);
        chk("s1_data2", 32'(m_tdata_o), 32'h110);
        chk("s1_user2", 32'(m_tuser_o), 32'd1);
        @(posedge clk);
        #1;
        wait_done(1, 100);
        check_stream(8);
        check_gap(8);
        repeat (3) @(posedge clk);
        #1;
        chk("s1_ndone", 32'(done_cnt), 32'd1);
        chk("s1_idle", 32'(busy_o), 32'd0);

        // toggling ready
        rdy_mode = 1;
        start_frame();
        wait_done(1, 300);
        check_stream(8);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("s2_ndone", 32'(done_cnt), 32'd1);

        // ready held low: two reads issued, then stall
        rdy_mode = 2;
        start_frame();
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("s3_addr", addr_rd_o, 32'd18);
        chk("s3_vld", 32'(m_tvalid_o), 32'd1);
        chk("s3_head", 32'(m_tdata_o), 32'h110);
        chk("s3_iss", 32'(iss_cnt), 32'd2);
        @(posedge clk);
        #1 rdy_mode = 0;
        wait_done(1, 100);
        check_stream(8);
        check_gap(8);

        // continuous: two frames back to back
        repeat (2) @(posedge clk);
        #1 continuous_i = 1'b1;
        start_frame();
        wait_done(1, 100);
        continuous_i = 1'b0;
        wait_done(2, 100);
        check_stream(16);
        repeat (3) @(posedge clk);
        #1;
        chk("s4_ndone", 32'(done_cnt), 32'd2);
        chk("s4_idle", 32'(busy_o), 32'd0);

        // reset after three accepted pixels
        start_frame();
        for (int n = 0; n < 50 && acc_q.size() < 3; n++) @(negedge clk);
        chk("s5_acc3", 32'(acc_q.size()), 32'd3);
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("s5_vld", 32'(m_tvalid_o), 32'd0);
        chk("s5_addr", addr_rd_o, 32'd16);
        chk("s5_busy", 32'(busy_o), 32'd0);
        chk("s5_nacc", 32'(acc_q.size()), 32'd3);
        @(posedge clk);
        #1;
        start_frame();
        wait_done(1, 100);
        check_stream(8);

        // start pulsed mid-frame is ignored
        repeat (2) @(posedge clk);
        #1;
        start_frame();
        repeat (3) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_done(1, 100);
        repeat (20) @(posedge clk);
        #1;
        check_stream(8);
        chk("s6_ndone", 32'(done_cnt), 32'd1);
        chk("s6_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
